// File: rtl/ram_to_stream_pkg.sv
// Geometry shared with the inbound stream-to-RAM buffer, plus the AR state type.
package ram_to_stream_pkg;

    localparam int unsigned CYCLES_PER_RAM_BLOCK = 64;
    localparam int unsigned GEOM_DW              = 512;
    localparam int unsigned ID_W                 = 4;
    localparam logic [63:0] RAM_BASE_ADDR        = 64'h0000_0001_0000_0000;

    // Bytes covered by one full burst at a given data width.
    function automatic int unsigned burst_bytes(input int unsigned dw);
        return CYCLES_PER_RAM_BLOCK * dw / 8;
    endfunction

    localparam int unsigned BURST_BYTES = burst_bytes(GEOM_DW);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN
    } ar_state_e;

endpackage

// File: rtl/ram_to_stream_if.sv
// AXI4 master (full AR/R/AW/W/B set) plus AXIS output bundle for ram_to_stream.
// master: the reader side (drives AR, RREADY, write channels, AXIS data);
// slave:  memory + stream sink side.
interface ram_to_stream_if
    import ram_to_stream_pkg::*;
#(
    parameter int unsigned DW = 512
);
    logic [63:0]     M_AXI_ARADDR;
    logic [7:0]      M_AXI_ARLEN;
    logic [2:0]      M_AXI_ARSIZE;
    logic [1:0]      M_AXI_ARBURST;
    logic [ID_W-1:0] M_AXI_ARID;
    logic            M_AXI_ARLOCK;
    logic [3:0]      M_AXI_ARCACHE;
    logic [3:0]      M_AXI_ARQOS;
    logic [2:0]      M_AXI_ARPROT;
    logic            M_AXI_ARVALID;
    logic            M_AXI_ARREADY;

    logic [DW-1:0]   M_AXI_RDATA;
    logic [1:0]      M_AXI_RRESP;
    logic            M_AXI_RLAST;
    logic [ID_W-1:0] M_AXI_RID;
    logic            M_AXI_RVALID;
    logic            M_AXI_RREADY;

    logic [63:0]     M_AXI_AWADDR;
    logic [7:0]      M_AXI_AWLEN;
    logic [2:0]      M_AXI_AWSIZE;
    logic [1:0]      M_AXI_AWBURST;
    logic [ID_W-1:0] M_AXI_AWID;
    logic            M_AXI_AWLOCK;
    logic [3:0]      M_AXI_AWCACHE;
    logic [3:0]      M_AXI_AWQOS;
    logic [2:0]      M_AXI_AWPROT;
    logic            M_AXI_AWVALID;
    logic            M_AXI_AWREADY;

    logic [DW-1:0]   M_AXI_WDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic            M_AXI_WLAST;
    logic            M_AXI_WVALID;
    logic            M_AXI_WREADY;

    logic [1:0]      M_AXI_BRESP;
    logic [ID_W-1:0] M_AXI_BID;
    logic            M_AXI_BVALID;
    logic            M_AXI_BREADY;

    logic [DW-1:0]   AXIS_OUT_TDATA;
    logic            AXIS_OUT_TVALID;
    logic            AXIS_OUT_TLAST;
    logic            AXIS_OUT_TREADY;

    modport master (
        output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARID,
               M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARQOS, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RID, M_AXI_RVALID,
        output M_AXI_RREADY,
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWID,
               M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWQOS, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BID, M_AXI_BVALID,
        output M_AXI_BREADY,
        output AXIS_OUT_TDATA, AXIS_OUT_TVALID, AXIS_OUT_TLAST,
        input  AXIS_OUT_TREADY
    );

    modport slave (
        input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARID,
               M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARQOS, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RID, M_AXI_RVALID,
        input  M_AXI_RREADY,
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWID,
               M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWQOS, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BID, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  AXIS_OUT_TDATA, AXIS_OUT_TVALID, AXIS_OUT_TLAST,
        output AXIS_OUT_TREADY
    );

endinterface

// File: rtl/rts_data_fifo.sv
// Read-data FIFO for ram_to_stream (stands in for an xpm_fifo_axis, common clock).
// Ports: s_axis_* write side (tdata/tlast/tvalid, tready = not full),
//        m_axis_* read side with a registered output stage.
// Total holding capacity is DEPTH array entries plus the output register.
module rts_data_fifo #(
    parameter int unsigned W     = 512,
    parameter int unsigned DEPTH = 256
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         s_axis_tvalid,
    input  logic [W-1:0] s_axis_tdata,
    input  logic         s_axis_tlast,
    output logic         s_axis_tready,
    output logic         m_axis_tvalid,
    output logic [W-1:0] m_axis_tdata,
    output logic         m_axis_tlast,
    input  logic         m_axis_tready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [W:0]    out_q, out_d;
    logic          push_c;
    logic          pop_c;

    // Pointer/count/output-stage update; the output register refills whenever it is free or drained.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        push_c      = s_axis_tvalid && (count_q != CW'(DEPTH));
        pop_c       = (count_q != '0) && (!out_valid_q || m_axis_tready);

        if (push_c) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d    = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            out_d       = mem[rd_ptr_q];
            out_valid_d = 1'b1;
        end else if (out_valid_q && m_axis_tready) begin
            out_valid_d = 1'b0;
        end
        count_d = count_q + CW'(push_c) - CW'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    // Storage array carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    assign s_axis_tready = (count_q != CW'(DEPTH));
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_q[W-1:0];
    assign m_axis_tlast  = out_q[W];

endmodule

// File: rtl/ram_to_stream.sv
// Reads a contiguous RAM region with AXI4 read bursts and replays it on AXIS.
// Ports: clk/resetn (sync, active-low); outflow_q/start/cycles_to_send launch a
// transfer; busy/done/rd_error/cycles_sent report status; m carries AXI4 + AXIS.
// Bursts are requested only against reserved FIFO space, so RREADY simply follows busy.
module ram_to_stream
    import ram_to_stream_pkg::*;
#(
    parameter int unsigned DW          = 512,
    parameter int unsigned CHANNEL     = 0,
    parameter int unsigned FIFO_BLOCKS = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        outflow_q,
    input  logic              start,
    input  logic [31:0]       cycles_to_send,
    output logic              busy,
    output logic              done,
    output logic              rd_error,
    output logic [31:0]       cycles_sent,
    ram_to_stream_if.master   m
);

    localparam int unsigned DEPTH       = FIFO_BLOCKS * CYCLES_PER_RAM_BLOCK;
    localparam logic [63:0] BURST_INC   = 64'(burst_bytes(DW));
    localparam logic [31:0] BLOCK_BEATS = 32'(CYCLES_PER_RAM_BLOCK);

    ar_state_e   state_q, state_d;
    logic [31:0] total_q, total_d;
    logic [31:0] issued_q, issued_d;
    logic [31:0] cycles_sent_q, cycles_sent_d;
    logic [31:0] reserved_q, reserved_d;
    logic [31:0] rcvd_q, rcvd_d;
    logic [31:0] burst_n_q, burst_n_d;
    logic [63:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic        arvalid_q, arvalid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rd_error_q, rd_error_d;

    logic          accept_c;
    logic          ar_hs_c;
    logic          r_hs_c;
    logic          t_hs_c;
    logic [31:0]   remaining_c;
    logic [31:0]   n_c;
    logic [31:0]   issued_next_c;
    logic          credit_ok_c;
    logic          fifo_s_last_c;
    logic          fifo_s_ready;
    logic          fifo_m_valid;
    logic          fifo_m_last;
    logic [DW-1:0] fifo_m_data;

    // Next-state, credit accounting and status.
    always_comb begin
        state_d       = state_q;
        total_d       = total_q;
        issued_d      = issued_q;
        cycles_sent_d = cycles_sent_q;
        reserved_d    = reserved_q;
        rcvd_d        = rcvd_q;
        burst_n_d     = burst_n_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        arvalid_d     = arvalid_q;
        busy_d        = busy_q;
        done_d        = done_q;
        rd_error_d    = rd_error_q;

        accept_c      = start && (outflow_q == 8'(CHANNEL)) && !busy_q;
        ar_hs_c       = arvalid_q && m.M_AXI_ARREADY;
        r_hs_c        = m.M_AXI_RVALID && busy_q;
        t_hs_c        = fifo_m_valid && m.AXIS_OUT_TREADY;
        remaining_c   = total_q - issued_q;
        n_c           = (remaining_c < BLOCK_BEATS) ? remaining_c : BLOCK_BEATS;
        issued_next_c = issued_q + burst_n_q;
        credit_ok_c   = ({1'b0, reserved_q} + {1'b0, n_c}) <= 33'(DEPTH);
        // TLAST is attached on the way into the FIFO; order is preserved so it lands on the final pop.
        fifo_s_last_c = (rcvd_q + 32'd1) == total_q;

        // A burst and a pop may land in the same cycle.
        reserved_d = reserved_q + (ar_hs_c ? burst_n_q : 32'd0) - (t_hs_c ? 32'd1 : 32'd0);

        if (r_hs_c) begin
            rcvd_d = rcvd_q + 32'd1;
            if (m.M_AXI_RRESP != 2'b00) begin
                rd_error_d = 1'b1;
            end
        end

        if (t_hs_c) begin
            cycles_sent_d = cycles_sent_q + 32'd1;
            if (fifo_m_last) begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    total_d       = cycles_to_send;
                    issued_d      = '0;
                    cycles_sent_d = '0;
                    reserved_d    = '0;
                    rcvd_d        = '0;
                    rd_error_d    = 1'b0;
                    araddr_d      = RAM_BASE_ADDR;
                    if (cycles_to_send == '0) begin
                        done_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (credit_ok_c) begin
                    arvalid_d = 1'b1;
                    arlen_d   = 8'(n_c - 32'd1);
                    burst_n_d = n_c;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ar_hs_c) begin
                    arvalid_d = 1'b0;
                    araddr_d  = araddr_q + BURST_INC;
                    issued_d  = issued_next_c;
                    state_d   = (issued_next_c < total_q) ? ST_REQ : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (t_hs_c && fifo_m_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            total_q       <= '0;
            issued_q      <= '0;
            cycles_sent_q <= '0;
            reserved_q    <= '0;
            rcvd_q        <= '0;
            burst_n_q     <= '0;
            araddr_q      <= RAM_BASE_ADDR;
            arlen_q       <= '0;
            arvalid_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rd_error_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            total_q       <= total_d;
            issued_q      <= issued_d;
            cycles_sent_q <= cycles_sent_d;
            reserved_q    <= reserved_d;
            rcvd_q        <= rcvd_d;
            burst_n_q     <= burst_n_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            arvalid_q     <= arvalid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rd_error_q    <= rd_error_d;
        end
    end

    rts_data_fifo #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tvalid (r_hs_c),
        .s_axis_tdata  (m.M_AXI_RDATA),
        .s_axis_tlast  (fifo_s_last_c),
        .s_axis_tready (fifo_s_ready),
        .m_axis_tvalid (fifo_m_valid),
        .m_axis_tdata  (fifo_m_data),
        .m_axis_tlast  (fifo_m_last),
        .m_axis_tready (m.AXIS_OUT_TREADY)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_error    = rd_error_q;
    assign cycles_sent = cycles_sent_q;

    assign m.M_AXI_ARADDR  = araddr_q;
    assign m.M_AXI_ARLEN   = arlen_q;
    assign m.M_AXI_ARVALID = arvalid_q;
    assign m.M_AXI_ARSIZE  = 3'($clog2(DW / 8));
    assign m.M_AXI_ARBURST = 2'b01;
    assign m.M_AXI_ARID    = '0;
    assign m.M_AXI_ARLOCK  = 1'b0;
    assign m.M_AXI_ARCACHE = '0;
    assign m.M_AXI_ARQOS   = '0;
    assign m.M_AXI_ARPROT  = '0;
    assign m.M_AXI_RREADY  = busy_q;

    // Read-only block: the write channels are present but permanently idle.
    assign m.M_AXI_AWADDR  = '0;
    assign m.M_AXI_AWLEN   = '0;
    assign m.M_AXI_AWSIZE  = '0;
    assign m.M_AXI_AWBURST = '0;
    assign m.M_AXI_AWID    = '0;
    assign m.M_AXI_AWLOCK  = 1'b0;
    assign m.M_AXI_AWCACHE = '0;
    assign m.M_AXI_AWQOS   = '0;
    assign m.M_AXI_AWPROT  = '0;
    assign m.M_AXI_AWVALID = 1'b0;
    assign m.M_AXI_WDATA   = '0;
    assign m.M_AXI_WSTRB   = '0;
    assign m.M_AXI_WLAST   = 1'b0;
    assign m.M_AXI_WVALID  = 1'b0;
    assign m.M_AXI_BREADY  = 1'b0;

    assign m.AXIS_OUT_TDATA  = fifo_m_data;
    assign m.AXIS_OUT_TVALID = fifo_m_valid;
    assign m.AXIS_OUT_TLAST  = fifo_m_last;

    // Inputs with no function here (RLAST is deliberately not checked).
    logic unused_ok_c;
    assign unused_ok_c = ^{m.M_AXI_RLAST, m.M_AXI_RID, m.M_AXI_AWREADY, m.M_AXI_WREADY,
                           m.M_AXI_BRESP, m.M_AXI_BID, m.M_AXI_BVALID, fifo_s_ready};

endmodule

// File: tb/tb_ram_to_stream.sv
module tb_ram_to_stream;
    import ram_to_stream_pkg::*;

    localparam int unsigned DW  = 512;
    localparam int          LAT = 10;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  outflow_q;
    logic        start;
    logic [31:0] cycles_to_send;
    logic        busy;
    logic        done;
    logic        rd_error;
    logic [31:0] cycles_sent;

    ram_to_stream_if #(.DW(DW)) bus ();

    ram_to_stream #(
        .DW          (DW),
        .CHANNEL     (0),
        .FIFO_BLOCKS (4)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .outflow_q      (outflow_q),
        .start          (start),
        .cycles_to_send (cycles_to_send),
        .busy           (busy),
        .done           (done),
        .rd_error       (rd_error),
        .cycles_sent    (cycles_sent),
        .m              (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        int          ready_cyc;
    } burst_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    ar_t    exp_ar[$];
    beat_t  exp_beat[$];
    burst_t bursts[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cur_beat = 0;
    int rbeat    = 0;
    int err_beat = -1;
    int ar_count = 0;
    int t_count  = 0;
    bit last_hs  = 1'b0;
    bit tvalid_seen = 1'b0;

    function automatic logic [DW-1:0] pattern(input logic [63:0] a);
        return {4{a, ~a ^ 64'h0123_4567_89ab_cdef}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at negedge, then play the memory slave after the edge.
    task automatic tick();
        bit    ar_hs;
        bit    r_hs;
        bit    t_hs;
        ar_t   ea;
        beat_t eb;
        @(negedge clk);
        ar_hs   = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
        r_hs    = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
        t_hs    = bus.AXIS_OUT_TVALID && bus.AXIS_OUT_TREADY;
        last_hs = 1'b0;
        if (bus.AXIS_OUT_TVALID) tvalid_seen = 1'b1;
        if (bus.M_AXI_RVALID) chk("rready", 512'(bus.M_AXI_RREADY), 512'(1));
        if (ar_hs) begin
            ar_count++;
            if (exp_ar.size() == 0) begin
                chk("ar_unexpected", 512'(1), 512'(0));
            end else begin
                ea = exp_ar.pop_front();
                chk("araddr", 512'(bus.M_AXI_ARADDR), 512'(ea.addr));
                chk("arlen", 512'(bus.M_AXI_ARLEN), 512'(ea.len));
            end
            chk("arsize_burst", 512'({bus.M_AXI_ARSIZE, bus.M_AXI_ARBURST}), 512'({3'd6, 2'd1}));
            chk("ar_side", 512'({bus.M_AXI_ARID, bus.M_AXI_ARLOCK, bus.M_AXI_ARCACHE,
                                 bus.M_AXI_ARQOS, bus.M_AXI_ARPROT}), 512'(0));
            bursts.push_back('{bus.M_AXI_ARADDR, bus.M_AXI_ARLEN, cyc + LAT});
        end
        if (t_hs) begin
            t_count++;
            if (exp_beat.size() == 0) begin
                chk("beat_unexpected", 512'(1), 512'(0));
            end else begin
                eb = exp_beat.pop_front();
                chk("tdata", bus.AXIS_OUT_TDATA, eb.data);
                chk("tlast", 512'(bus.AXIS_OUT_TLAST), 512'(eb.last));
                last_hs = eb.last;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (r_hs && bursts.size() > 0) begin
            rbeat++;
            if (cur_beat == 32'(bursts[0].len)) begin
                void'(bursts.pop_front());
                cur_beat = 0;
            end else begin
                cur_beat++;
            end
        end
        if (bursts.size() > 0 && bursts[0].ready_cyc <= cyc) begin
            bus.M_AXI_RVALID = 1'b1;
            bus.M_AXI_RDATA  = pattern(bursts[0].addr + 64'(cur_beat) * 64'd64);
            bus.M_AXI_RLAST  = (cur_beat == 32'(bursts[0].len));
            bus.M_AXI_RRESP  = (rbeat == err_beat) ? 2'd2 : 2'd0;
        end else begin
            bus.M_AXI_RVALID = 1'b0;
            bus.M_AXI_RLAST  = 1'b0;
            bus.M_AXI_RRESP  = 2'd0;
        end
    endtask

    // Queue expected ARs and beats, then pulse start for one clock.
    task automatic launch(input int n);
        for (int off = 0; off < n; off += 64) begin
            exp_ar.push_back('{RAM_BASE_ADDR + 64'(off / 64) * 64'(BURST_BYTES),
                               8'((((n - off) < 64) ? (n - off) : 64) - 1)});
        end
        for (int k = 0; k < n; k++) begin
            exp_beat.push_back('{pattern(RAM_BASE_ADDR + 64'(k) * 64'd64), (k == n - 1)});
        end
        rbeat          = 0;
        ar_count       = 0;
        t_count        = 0;
        tvalid_seen    = 1'b0;
        start          = 1'b1;
        cycles_to_send = 32'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (last_hs) begin
                got = 1'b1;
                chk("done_after_last", 512'(done), 512'(1));
                chk("busy_after_last", 512'(busy), 512'(0));
            end
        end
        chk("completed_in_budget", 512'(got), 512'(1));
        chk("beats_left", 512'(exp_beat.size()), 512'(0));
        chk("ars_left", 512'(exp_ar.size()), 512'(0));
    endtask

    initial begin
        resetn              = 1'b0;
        start               = 1'b0;
        outflow_q           = 8'd0;
        cycles_to_send      = '0;
        bus.M_AXI_ARREADY   = 1'b1;
        bus.M_AXI_RVALID    = 1'b0;
        bus.M_AXI_RDATA     = '0;
        bus.M_AXI_RRESP     = 2'd0;
        bus.M_AXI_RLAST     = 1'b0;
        bus.M_AXI_RID       = '0;
        bus.M_AXI_AWREADY   = 1'b0;
        bus.M_AXI_WREADY    = 1'b0;
        bus.M_AXI_BVALID    = 1'b0;
        bus.M_AXI_BRESP     = 2'd0;
        bus.M_AXI_BID       = '0;
        bus.AXIS_OUT_TREADY = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_rd_error", 512'(rd_error), 512'(0));
        chk("rst_cycles_sent", 512'(cycles_sent), 512'(0));
        chk("rst_arvalid", 512'(bus.M_AXI_ARVALID), 512'(0));
        chk("rst_araddr", 512'(bus.M_AXI_ARADDR), 512'(RAM_BASE_ADDR));
        chk("rst_tvalid", 512'(bus.AXIS_OUT_TVALID), 512'(0));
        resetn = 1'b1;
        tick();

        // Start addressed to another channel is ignored.
        outflow_q      = 8'd3;
        start          = 1'b1;
        cycles_to_send = 32'd5;
        ar_count       = 0;
        tick();
        start     = 1'b0;
        outflow_q = 8'd0;
        repeat (4) tick();
        chk("other_channel_busy", 512'(busy), 512'(0));
        chk("other_channel_no_ar", 512'(ar_count), 512'(0));

        // 128 beats: two full bursts, AR two cycles after start, start-while-busy ignored.
        launch(128);
        chk("t1_busy", 512'(busy), 512'(1));
        chk("t1_done_clear", 512'(done), 512'(0));
        tick();
        chk("t1_ar_latency", 512'(bus.M_AXI_ARVALID), 512'(1));
        start          = 1'b1;
        cycles_to_send = 32'd7;
        tick();
        start = 1'b0;
        wait_done(2000);
        chk("t1_cycles_sent", 512'(cycles_sent), 512'(128));
        chk("t1_ar_count", 512'(ar_count), 512'(2));
        repeat (3) tick();
        chk("t1_done_held", 512'(done), 512'(1));

        // 70 beats: full burst then a 6-beat remainder.
        launch(70);
        chk("t2_done_clear", 512'(done), 512'(0));
        wait_done(2000);
        chk("t2_cycles_sent", 512'(cycles_sent), 512'(70));
        chk("t2_ar_count", 512'(ar_count), 512'(2));

        // Zero-length transfer.
        launch(0);
        chk("t3_done", 512'(done), 512'(1));
        chk("t3_busy", 512'(busy), 512'(0));
        repeat (20) tick();
        chk("t3_no_ar", 512'(ar_count), 512'(0));
        chk("t3_no_tvalid", 512'(tvalid_seen), 512'(0));
        chk("t3_cycles_sent", 512'(cycles_sent), 512'(0));

        // 1024 beats with the sink stalled: credit caps outstanding bursts at four.
        bus.AXIS_OUT_TREADY = 1'b0;
        launch(1024);
        repeat (2000) tick();
        chk("t4_ar_capped", 512'(ar_count), 512'(4));
        chk("t4_tvalid_held", 512'(bus.AXIS_OUT_TVALID), 512'(1));
        chk("t4_no_beats", 512'(t_count), 512'(0));
        chk("t4_busy", 512'(busy), 512'(1));
        bus.AXIS_OUT_TREADY = 1'b1;
        wait_done(6000);
        chk("t4_cycles_sent", 512'(cycles_sent), 512'(1024));
        chk("t4_ar_count", 512'(ar_count), 512'(16));

        // Error response on the 10th beat: sticky, data still delivered.
        err_beat = 9;
        launch(64);
        wait_done(1000);
        err_beat = -1;
        chk("t5_cycles_sent", 512'(cycles_sent), 512'(64));
        repeat (3) tick();
        chk("t5_rd_error", 512'(rd_error), 512'(1));
        launch(16);
        chk("t5_rd_error_cleared", 512'(rd_error), 512'(0));
        wait_done(500);
        chk("t5b_rd_error", 512'(rd_error), 512'(0));

        // Reset at beat 30 of 128, then a clean 16-beat transfer.
        launch(128);
        for (int i = 0; i < 2000 && t_count < 30; i++) tick();
        chk("t6_reached_beat30", 512'(t_count), 512'(30));
        resetn = 1'b0;
        tick();
        bursts.delete();
        exp_ar.delete();
        exp_beat.delete();
        cur_beat         = 0;
        bus.M_AXI_RVALID = 1'b0;
        bus.M_AXI_RLAST  = 1'b0;
        bus.M_AXI_RRESP  = 2'd0;
        chk("t6_busy", 512'(busy), 512'(0));
        chk("t6_done", 512'(done), 512'(0));
        chk("t6_rd_error", 512'(rd_error), 512'(0));
        chk("t6_cycles_sent", 512'(cycles_sent), 512'(0));
        chk("t6_arvalid", 512'(bus.M_AXI_ARVALID), 512'(0));
        chk("t6_araddr", 512'(bus.M_AXI_ARADDR), 512'(RAM_BASE_ADDR));
        chk("t6_tvalid", 512'(bus.AXIS_OUT_TVALID), 512'(0));
        resetn = 1'b1;
        tick();
        launch(16);
        wait_done(500);
        chk("t6b_cycles_sent", 512'(cycles_sent), 512'(16));
        chk("t6b_ar_count", 512'(ar_count), 512'(1));

        chk("write_channels_idle", 512'(|{bus.M_AXI_AWADDR, bus.M_AXI_AWLEN, bus.M_AXI_AWSIZE,
                                          bus.M_AXI_AWBURST, bus.M_AXI_AWID, bus.M_AXI_AWLOCK,
                                          bus.M_AXI_AWCACHE, bus.M_AXI_AWQOS, bus.M_AXI_AWPROT,
                                          bus.M_AXI_AWVALID, bus.M_AXI_WDATA, bus.M_AXI_WSTRB,
                                          bus.M_AXI_WLAST, bus.M_AXI_WVALID, bus.M_AXI_BREADY}),
            512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_to_stream.md
Name: ram_to_stream

Overview:
- Reads a contiguous region of RAM over AXI4 read bursts and replays it as an AXI4-Stream. It is the outbound counterpart to the inbound stream-to-RAM buffer.
- A transfer is launched by a start pulse and sized by a beat count. Full-size bursts are issued first, then one partial burst for any remainder.
- Read data passes through an internal FIFO. Bursts are issued only when FIFO space is already reserved, so the R channel never needs backpressure.

Parameters:
- DW, 512, data width in bits for both AXI and AXIS.
- CHANNEL, 0, channel ID; start is honoured only when outflow_q == CHANNEL.
- FIFO_BLOCKS, 4, FIFO depth expressed in bursts; depth = FIFO_BLOCKS*CYCLES_PER_RAM_BLOCK.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- outflow_q  in  8  ID of the channel currently selected for output.
- start  in  1  one-cycle pulse that begins a transfer.
- cycles_to_send  in  32  number of DW beats to read; sampled on start.
- busy  out  1  high from accepted start until done.
- done  out  1  high once the final AXIS beat is accepted; held until the next start.
- rd_error  out  1  sticky; set on any RRESP != 0; cleared on start.
- cycles_sent  out  32  count of AXIS beats accepted in the current transfer.
- AXIS_OUT_TDATA  out  DW  / AXIS_OUT_TVALID out 1 / AXIS_OUT_TLAST out 1 / AXIS_OUT_TREADY in 1.
- M_AXI_ARADDR out 64 / ARLEN out 8 / ARVALID out 1 / ARREADY in 1 / ARSIZE,ARBURST,ARID,ARLOCK,ARCACHE,ARQOS,ARPROT out constants.
- M_AXI_RDATA in DW / RVALID in 1 / RRESP in 2 / RLAST in 1 / RREADY out 1.
- M_AXI_AW*, W*, B* ports: full set present. Outputs are tied to 0, except BREADY=0 and WSTRB=0.

Behaviour:
- Reset values: busy=0, done=0, rd_error=0, cycles_sent=0, ARVALID=0, ARADDR=RAM_BASE_ADDR, AXIS_OUT_TVALID=0. The FIFO is reset by the same resetn.
- Start acceptance: start is accepted only when start=1, outflow_q==CHANNEL and busy=0. A start while busy is ignored.
- On accept:
  - latch total=cycles_to_send;
  - clear issued, cycles_sent, rd_error and done;
  - set ARADDR=RAM_BASE_ADDR;
  - set busy=1.
- Zero-length transfer: if total==0, done=1 and busy=0 on the next cycle. No AR is issued and TVALID never asserts.
- Credit rule:
  - reserved = beats requested minus beats popped to AXIS.
  - An AR for a burst of n beats may assert only if reserved+n <= FIFO depth.
  - reserved increments by n on the AR handshake and decrements on each AXIS handshake; both may occur in the same cycle.
- AR state machine:
  - IDLE→REQ on accept with total>0.
  - REQ: n = min(CYCLES_PER_RAM_BLOCK, total-issued). Once the credit rule is satisfied, drive ARLEN=n-1 and ARVALID=1, then go to WAIT.
  - WAIT: on the ARVALID&ARREADY handshake, drop ARVALID, add BURST_BYTES to ARADDR, and add n to issued. Go to REQ if issued<total, otherwise go to DRAIN.
  - DRAIN→IDLE when done is set.
  - ARVALID and ARADDR/ARLEN are held stable until the handshake.
- Start-to-AR latency: the first ARVALID asserts 2 cycles after the start pulse (accept cycle + REQ cycle), provided credit is available.
- R channel: RREADY=busy. Each RVALID beat is pushed to the FIFO unconditionally; the credit rule guarantees space. RLAST is not checked.
- AXIS output: driven directly from the FIFO output. TDATA/TVALID are held while TREADY=0, and beat order is preserved.
- TLAST: asserted on the beat where cycles_sent+1 == total.
- Completion: on that final handshake, done=1 and busy=0 in the next cycle.
- Error: any RVALID&RREADY with RRESP != 0 sets rd_error. The data is still forwarded and the transfer completes normally.
- Reset mid-transfer: everything returns to reset values immediately; FIFO contents and outstanding bursts are discarded. The interconnect must be quiesced by the same reset.
- Width rules:
  - issued, total, cycles_sent and reserved are 32-bit.
  - BURST_BYTES = CYCLES_PER_RAM_BLOCK*DW/8.
  - ARADDR wraps modulo 2^64; no 4 KB-boundary check is done.
- Constants: ARSIZE=$clog2(DW/8), ARBURST=1 (INCR), all other AR sideband fields 0.

Decomposition:
- Shared geometry package holds RAM_BASE_ADDR, CYCLES_PER_RAM_BLOCK and BURST_BYTES, the same constants used by the inbound buffer.
- One sub-module: the read-data FIFO, an xpm_fifo_axis instance wrapped as rts_data_fifo, with depth FIFO_BLOCKS*CYCLES_PER_RAM_BLOCK and common clock.
- AR state machine, credit counter and TLAST/done logic stay in ram_to_stream.

Test Plan:
Bench settings: DW=512, CYCLES_PER_RAM_BLOCK=64, BURST_BYTES=4096, slave latency 10 cycles, TREADY=1 unless stated.
- cycles_to_send=128 → two ARs (base, ARLEN=63; base+4096, ARLEN=63); 128 beats in address order; TLAST only on beat 128; done=1 the cycle after; cycles_sent=128.
- cycles_to_send=70 → ARs with ARLEN=63 then ARLEN=5 at base+4096; TLAST on beat 70; done=1.
- cycles_to_send=0 → no ARVALID; done=1 one cycle after start; TVALID stays 0.
- cycles_to_send=1024, TREADY=0 for 2000 cycles → exactly 4 ARs issued (256 beats of credit); RREADY never drops during R beats; releasing TREADY gives 1024 ordered beats and done.
- cycles_to_send=64, RRESP=2 on beat 10 → rd_error=1 stays set; all 64 beats emitted; done=1. A new start clears rd_error.
- resetn=0 held 1 cycle at beat 30 of 128 → all outputs at reset values; a subsequent start of 16 completes cleanly with ARADDR=base.
